ad9866_gain_ctrl: RTL and testbench

Upstream sequencer for the AD9866 SPI configuration block. It takes free-running RX/TX gain settings from the host command path and detects changes. It then issues one-at-a-time gain write requests (ext_rx_rqst/ext_tx_rqst with stable rx_gain/tx_gain) to the SPI block. It tracks SPI activity through sen_n, so requests never collide with the power-up init sequence or with each other.

---
 rtl/ad9866_gain_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ad9866_gain_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9866_gain_ctrl.sv
// Gain-write sequencer for the AD9866 SPI block: detects host RX/TX gain changes
// and issues one request at a time, paced by the SPI enable (sen_n).
module ad9866_gain_ctrl #(
  parameter int          INIT_WAIT     = 2048,
  parameter int          START_TIMEOUT = 256,
  parameter int          MIN_GAP       = 16,
  parameter logic [5:0]  RX_GAIN_RST   = 6'h00,
  parameter logic [5:0]  TX_GAIN_RST   = 6'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] host_rx_gain,
  input  logic [5:0] host_tx_gain,
  input  logic       refresh,
  input  logic       sen_n,
  output logic       ext_rx_rqst,
  output logic [5:0] rx_gain,
  output logic       ext_tx_rqst,
  output logic [5:0] tx_gain,
  output logic       busy,
  output logic       timeout_err
);

  localparam int CNT_MAX = (INIT_WAIT > START_TIMEOUT)
                         ? ((INIT_WAIT > MIN_GAP) ? INIT_WAIT : MIN_GAP)
                         : ((START_TIMEOUT > MIN_GAP) ? START_TIMEOUT : MIN_GAP);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(MIN_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_XFER = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rx_rqst;
  logic             r_tx_rqst;
  logic [5:0]       r_rx_gain;
  logic [5:0]       r_tx_gain;
  logic [5:0]       r_shadow_rx;
  logic [5:0]       r_shadow_tx;
  logic             r_rx_valid;
  logic             r_tx_valid;
  logic             r_rr_last;
  logic             r_sel;
  logic             r_timeout_err;

  logic w_rx_pend;
  logic w_tx_pend;
  logic w_pick_tx;

  assign w_rx_pend = !r_rx_valid || (host_rx_gain != r_shadow_rx);
  assign w_tx_pend = !r_tx_valid || (host_tx_gain != r_shadow_tx);
  // With both pending, serve whichever channel was not serviced last.
  assign w_pick_tx = w_tx_pend && (!w_rx_pend || !r_rr_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_INIT;
      r_cnt         <= CNT_ZERO;
      r_rx_rqst     <= 1'b0;
      r_tx_rqst     <= 1'b0;
      r_rx_gain     <= RX_GAIN_RST;
      r_tx_gain     <= TX_GAIN_RST;
      r_shadow_rx   <= 6'h00;
      r_shadow_tx   <= 6'h00;
      r_rx_valid    <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_rr_last     <= 1'b1;
      r_sel         <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_cnt == INIT_LAST) begin
            if (sen_n) begin
              r_state <= S_IDLE;
              r_cnt   <= CNT_ZERO;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_IDLE: begin
          if (w_rx_pend || w_tx_pend) begin
            r_state <= S_REQ;
            r_cnt   <= CNT_ZERO;
            r_sel   <= w_pick_tx;
            if (w_pick_tx) begin
              r_tx_gain <= host_tx_gain;
              r_tx_rqst <= 1'b1;
            end else begin
              r_rx_gain <= host_rx_gain;
              r_rx_rqst <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (!sen_n) begin
            r_rx_rqst <= 1'b0;
            r_tx_rqst <= 1'b0;
            r_state   <= S_XFER;
          end else if (r_cnt == TO_LAST) begin
            // Abandoned: shadow untouched, so the channel re-pends after the gap.
            r_rx_rqst     <= 1'b0;
            r_tx_rqst     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= S_GAP;
            r_cnt         <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_XFER: begin
          if (sen_n) begin
            if (r_sel) begin
              r_shadow_tx <= r_tx_gain;
              r_tx_valid  <= 1'b1;
            end else begin
              r_shadow_rx <= r_rx_gain;
              r_rx_valid  <= 1'b1;
            end
            r_rr_last <= r_sel;
            r_state   <= S_GAP;
            r_cnt     <= CNT_ZERO;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state   <= S_INIT;
          r_cnt     <= CNT_ZERO;
          r_rx_rqst <= 1'b0;
          r_tx_rqst <= 1'b0;
        end
      endcase
      // Placed last so a refresh overrides a completion in the same cycle.
      if (refresh) begin
        r_rx_valid <= 1'b0;
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign ext_rx_rqst = r_rx_rqst;
  assign ext_tx_rqst = r_tx_rqst;
  assign rx_gain     = r_rx_gain;
  assign tx_gain     = r_tx_gain;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ad9866_gain_ctrl.sv
// Directed bench for ad9866_gain_ctrl with a behavioural SPI responder.
module tb_ad9866_gain_ctrl;

  localparam int INIT_WAIT     = 2048;
  localparam int START_TIMEOUT = 256;
  localparam int MIN_GAP       = 16;

  logic       clk;
  logic       reset_n;
  logic [5:0] host_rx_gain;
  logic [5:0] host_tx_gain;
  logic       refresh;
  logic       sen_n;
  logic       ext_rx_rqst;
  logic [5:0] rx_gain;
  logic       ext_tx_rqst;
  logic [5:0] tx_gain;
  logic       busy;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;
  bit spi_en = 1'b1;

  int log_ch[$];
  int log_gain[$];
  int gaps[$];

  ad9866_gain_ctrl #(
    .INIT_WAIT(INIT_WAIT), .START_TIMEOUT(START_TIMEOUT), .MIN_GAP(MIN_GAP),
    .RX_GAIN_RST(6'h00), .TX_GAIN_RST(6'h00)
  ) dut (
    .clk(clk), .reset_n(reset_n), .host_rx_gain(host_rx_gain), .host_tx_gain(host_tx_gain),
    .refresh(refresh), .sen_n(sen_n), .ext_rx_rqst(ext_rx_rqst), .rx_gain(rx_gain),
    .ext_tx_rqst(ext_tx_rqst), .tx_gain(tx_gain), .busy(busy), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SPI responder: sen_n low 3 cycles after a request, for 34 cycles.
  initial begin
    sen_n = 1'b1;
    forever begin
      @(posedge clk);
      if (spi_en && reset_n && (ext_rx_rqst || ext_tx_rqst)) begin
        repeat (2) @(posedge clk);
        #1;
        if (ext_rx_rqst) begin
          log_ch.push_back(0);
          log_gain.push_back(int'(rx_gain));
        end else begin
          log_ch.push_back(1);
          log_gain.push_back(int'(tx_gain));
        end
        sen_n = 1'b0;
        repeat (34) @(posedge clk);
        #1 sen_n = 1'b1;
      end
    end
  end

  logic       mon_any;
  logic       prev_any = 1'b0;
  logic       prev_sen = 1'b1;
  logic       prev_rx_rqst = 1'b0;
  logic       prev_tx_rqst = 1'b0;
  logic [5:0] prev_rx_gain = 6'h00;
  logic [5:0] prev_tx_gain = 6'h00;
  int idle_run = 0;
  int cur_len = 0;
  int last_len = 0;
  int overlap_cnt = 0;
  int late_drop = 0;
  int gain_viol = 0;

  assign mon_any = ext_rx_rqst | ext_tx_rqst;

  always @(negedge clk) begin
    prev_sen     <= sen_n;
    prev_any     <= mon_any;
    prev_rx_rqst <= ext_rx_rqst;
    prev_tx_rqst <= ext_tx_rqst;
    prev_rx_gain <= rx_gain;
    prev_tx_gain <= tx_gain;
    if (reset_n) begin
      if (ext_rx_rqst && ext_tx_rqst) overlap_cnt <= overlap_cnt + 1;
      if (!prev_sen && mon_any) late_drop <= late_drop + 1;
      if (rx_gain !== prev_rx_gain && !(ext_rx_rqst && !prev_rx_rqst)) gain_viol <= gain_viol + 1;
      if (tx_gain !== prev_tx_gain && !(ext_tx_rqst && !prev_tx_rqst)) gain_viol <= gain_viol + 1;
      if (mon_any) begin
        cur_len  <= cur_len + 1;
        idle_run <= 0;
        if (!prev_any) gaps.push_back(idle_run);
      end else begin
        if (cur_len != 0) last_len <= cur_len;
        cur_len  <= 0;
        idle_run <= sen_n ? idle_run + 1 : 0;
      end
    end else begin
      idle_run <= 0;
      cur_len  <= 0;
    end
  end

  function automatic int lg_ch(input int i);
    return (i < log_ch.size()) ? log_ch[i] : -1;
  endfunction

  function automatic int lg_gain(input int i);
    return (i < log_gain.size()) ? log_gain[i] : -1;
  endfunction

  function automatic int gap_at(input int i);
    return (i < gaps.size()) ? gaps[i] : -1;
  endfunction

  task automatic wait_quiet(input int budget, output bit ok);
    int q;
    q  = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && sen_n) q++;
      else q = 0;
      if (q >= 4) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_first_rqst(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (mon_any) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_sen_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!sen_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int n;
    int lb;
    bit ok;
    reset_n = 1'b0;
    host_rx_gain = 6'h15;
    host_tx_gain = 6'h0A;
    refresh = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ext_rx_rqst !== 1'b0 || ext_tx_rqst !== 1'b0) begin
      errors++; $display("FAIL reset_rqst: got %b%b want 00", ext_rx_rqst, ext_tx_rqst);
    end
    checks++;
    if (rx_gain !== 6'h00 || tx_gain !== 6'h00) begin
      errors++; $display("FAIL reset_gain: got %h/%h want 00/00", rx_gain, tx_gain);
    end
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b terr=%b want 1/0", busy, timeout_err);
    end
    lb = log_ch.size();
    reset_n = 1'b1;
    wait_first_rqst(INIT_WAIT + 100, n);
    checks++;
    if (n <= INIT_WAIT) begin
      errors++; $display("FAIL init_wait: first rqst after %0d cycles, want > %0d", n, INIT_WAIT);
    end
    wait_quiet(1000, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL init_quiet: got timeout want idle");
    end
    checks++;
    if (lg_ch(lb) !== 0 || lg_gain(lb) !== 'h15) begin
      errors++; $display("FAIL init_rx_write: got ch=%0d gain=%0h want ch=0 gain=15", lg_ch(lb), lg_gain(lb));
    end
    checks++;
    if (lg_ch(lb + 1) !== 1 || lg_gain(lb + 1) !== 'h0A) begin
      errors++; $display("FAIL init_tx_write: got ch=%0d gain=%0h want ch=1 gain=a", lg_ch(lb + 1), lg_gain(lb + 1));
    end
    checks++;
    if (log_ch.size() !== lb + 2 || busy !== 1'b0) begin
      errors++; $display("FAIL init_done: writes=%0d busy=%b want 2/0", log_ch.size() - lb, busy);
    end
  endtask

  task automatic test_rx_change;
    int lb;
    bit ok;
    lb = log_ch.size();
    @(posedge clk);
    #1 host_rx_gain = 6'h20;
    wait_quiet(500, ok);
    checks++;
    if (!ok || log_ch.size() !== lb + 1) begin
      errors++; $display("FAIL rx_change_count: got %0d writes (ok=%b) want 1", log_ch.size() - lb, ok);
    end
    checks++;
    if (lg_ch(lb) !== 0 || lg_gain(lb) !== 'h20) begin
      errors++; $display("FAIL rx_change_write: got ch=%0d gain=%0h want ch=0 gain=20", lg_ch(lb), lg_gain(lb));
    end
    checks++;
    if (late_drop !== 0) begin
      errors++; $display("FAIL rqst_drop: got %0d late drops want 0", late_drop);
    end
  endtask

  task automatic test_both_change;
    int lb;
    int g0;
    bit ok;
    lb = log_ch.size();
    g0 = gaps.size();
    @(posedge clk);
    #1;
    host_rx_gain = 6'h11;
    host_tx_gain = 6'h22;
    wait_quiet(1000, ok);
    checks++;
    if (!ok || log_ch.size() !== lb + 2) begin
      errors++; $display("FAIL both_count: got %0d writes (ok=%b) want 2", log_ch.size() - lb, ok);
    end
    checks++;
    if (lg_ch(lb) !== 1 || lg_gain(lb) !== 'h22) begin
      errors++; $display("FAIL both_first_tx: got ch=%0d gain=%0h want ch=1 gain=22", lg_ch(lb), lg_gain(lb));
    end
    checks++;
    if (lg_ch(lb + 1) !== 0 || lg_gain(lb + 1) !== 'h11) begin
      errors++; $display("FAIL both_then_rx: got ch=%0d gain=%0h want ch=0 gain=11", lg_ch(lb + 1), lg_gain(lb + 1));
    end
    checks++;
    if (gap_at(g0 + 1) < MIN_GAP) begin
      errors++; $display("FAIL both_gap: got %0d idle cycles want >= %0d", gap_at(g0 + 1), MIN_GAP);
    end
    checks++;
    if (overlap_cnt !== 0) begin
      errors++; $display("FAIL overlap: got %0d overlapping cycles want 0", overlap_cnt);
    end
  endtask

  task automatic test_timeout;
    int lb;
    int g0;
    int n;
    bit ok;
    bit fell;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL terr_before: got %b want 0", timeout_err);
    end
    spi_en = 1'b0;
    lb = log_ch.size();
    g0 = gaps.size();
    @(posedge clk);
    #1 host_rx_gain = 6'h05;
    wait_first_rqst(50, n);
    fell = 1'b0;
    for (int i = 0; i < START_TIMEOUT + 50; i++) begin
      @(negedge clk);
      if (!mon_any) begin
        fell = 1'b1;
        break;
      end
    end
    spi_en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (n < 0 || !fell || last_len !== START_TIMEOUT) begin
      errors++; $display("FAIL timeout_len: got %0d cycles want %0d", last_len, START_TIMEOUT);
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_flag: got %b want 1", timeout_err);
    end
    wait_quiet(500, ok);
    checks++;
    if (gap_at(g0 + 1) !== MIN_GAP + 1) begin
      errors++; $display("FAIL retry_gap: got %0d want %0d", gap_at(g0 + 1), MIN_GAP + 1);
    end
    checks++;
    if (!ok || log_ch.size() !== lb + 1 || lg_ch(lb) !== 0 || lg_gain(lb) !== 'h05) begin
      errors++; $display("FAIL retry_write: got n=%0d ch=%0d gain=%0h want 1/0/5", log_ch.size() - lb, lg_ch(lb), lg_gain(lb));
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b want 1", timeout_err);
    end
  endtask

  task automatic test_xfer_change;
    int lb;
    bit ok;
    bit low;
    lb = log_ch.size();
    @(posedge clk);
    #1 host_rx_gain = 6'h20;
    wait_sen_low(100, low);
    host_rx_gain = 6'h2F;
    wait_quiet(1000, ok);
    checks++;
    if (!low || !ok || log_ch.size() !== lb + 2) begin
      errors++; $display("FAIL xfer_change_count: got %0d writes want 2", log_ch.size() - lb);
    end
    checks++;
    if (lg_gain(lb) !== 'h20 || lg_ch(lb) !== 0) begin
      errors++; $display("FAIL xfer_first: got ch=%0d gain=%0h want ch=0 gain=20", lg_ch(lb), lg_gain(lb));
    end
    checks++;
    if (lg_gain(lb + 1) !== 'h2F || lg_ch(lb + 1) !== 0) begin
      errors++; $display("FAIL xfer_rewrite: got ch=%0d gain=%0h want ch=0 gain=2f", lg_ch(lb + 1), lg_gain(lb + 1));
    end
  endtask

  task automatic test_refresh;
    int lb;
    bit ok;
    lb = log_ch.size();
    @(posedge clk);
    #1 refresh = 1'b1;
    @(posedge clk);
    #1 refresh = 1'b0;
    wait_quiet(1000, ok);
    checks++;
    if (!ok || log_ch.size() !== lb + 2) begin
      errors++; $display("FAIL refresh_count: got %0d writes want 2", log_ch.size() - lb);
    end
    checks++;
    if (lg_ch(lb) !== 1 || lg_gain(lb) !== 'h22 || lg_ch(lb + 1) !== 0 || lg_gain(lb + 1) !== 'h2F) begin
      errors++; $display("FAIL refresh_writes: got %0d:%0h %0d:%0h want 1:22 0:2f",
                         lg_ch(lb), lg_gain(lb), lg_ch(lb + 1), lg_gain(lb + 1));
    end
  endtask

  task automatic test_reset_mid_xfer;
    int lb;
    int n;
    bit ok;
    bit low;
    @(posedge clk);
    #1 host_tx_gain = 6'h30;
    wait_sen_low(100, low);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (!low || ext_rx_rqst !== 1'b0 || ext_tx_rqst !== 1'b0 || rx_gain !== 6'h00 || tx_gain !== 6'h00) begin
      errors++; $display("FAIL midreset_out: got rq=%b%b gains=%h/%h want 00 00/00",
                         ext_rx_rqst, ext_tx_rqst, rx_gain, tx_gain);
    end
    checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: busy=%b terr=%b want 1/0", busy, timeout_err);
    end
    repeat (2) @(posedge clk);
    #3;
    lb = log_ch.size();
    reset_n = 1'b1;
    wait_first_rqst(INIT_WAIT + 100, n);
    checks++;
    if (n <= INIT_WAIT) begin
      errors++; $display("FAIL midreset_init: first rqst after %0d cycles want > %0d", n, INIT_WAIT);
    end
    wait_quiet(1000, ok);
    checks++;
    if (!ok || lg_ch(lb) !== 0 || lg_gain(lb) !== 'h2F || lg_ch(lb + 1) !== 1 || lg_gain(lb + 1) !== 'h30) begin
      errors++; $display("FAIL midreset_writes: got %0d:%0h %0d:%0h want 0:2f 1:30",
                         lg_ch(lb), lg_gain(lb), lg_ch(lb + 1), lg_gain(lb + 1));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    refresh = 1'b0;
    host_rx_gain = 6'h00;
    host_tx_gain = 6'h00;
    test_reset();
    test_rx_change();
    test_both_change();
    test_timeout();
    test_xfer_change();
    test_refresh();
    test_reset_mid_xfer();
    checks++;
    if (overlap_cnt !== 0 || late_drop !== 0 || gain_viol !== 0) begin
      errors++; $display("FAIL invariants: overlap=%0d late=%0d gainchg=%0d want 0/0/0",
                         overlap_cnt, late_drop, gain_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
